// File: rtl/cac_port_arbiter.sv
// Two-channel cache index arbiter: the core (cd) and snoop (su) channels each own
// at most one index; a request to an index held by the other channel stalls.
module cac_port_arbiter #(
    parameter int SADDR_WIDTH  = 32,
    parameter int OFS_WIDTH    = 6,
    parameter int IDX_WIDTH    = 8,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cd_req_vld,
    input  logic [SADDR_WIDTH-1:0] cd_req_addr,
    output logic                   cd_req_rdy,
    input  logic                   cd_done,
    input  logic                   su_req_vld,
    input  logic [SADDR_WIDTH-1:0] su_req_addr,
    output logic                   su_req_rdy,
    input  logic                   su_done,
    output logic                   cd_own,
    output logic [IDX_WIDTH-1:0]   cd_own_idx,
    output logic                   su_own,
    output logic [IDX_WIDTH-1:0]   su_own_idx,
    output logic                   cd_starve,
    output logic                   proto_err
);

    typedef enum logic {
        ST_FREE = 1'b0,
        ST_OWN  = 1'b1
    } own_state_t;

    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    own_state_t           r_cd_state;
    own_state_t           w_cd_state_nxt;
    own_state_t           r_su_state;
    own_state_t           w_su_state_nxt;
    logic [IDX_WIDTH-1:0] r_cd_own_idx;
    logic [IDX_WIDTH-1:0] r_su_own_idx;
    logic [3:0]           r_starve_cnt;
    logic [3:0]           w_starve_cnt_nxt;
    logic                 r_proto_err;

    logic [IDX_WIDTH-1:0] w_cd_idx;
    logic [IDX_WIDTH-1:0] w_su_idx;
    logic                 w_cd_own;
    logic                 w_su_own;
    logic                 w_cd_blk;
    logic                 w_su_blk;
    logic                 w_tie;
    logic                 w_cd_lose;
    logic                 w_su_lose;
    logic                 w_cd_starve;
    logic                 w_cd_acc;
    logic                 w_su_acc;
    logic                 w_unused_addr;

    assign w_cd_idx    = cd_req_addr[OFS_WIDTH+IDX_WIDTH-1:OFS_WIDTH];
    assign w_su_idx    = su_req_addr[OFS_WIDTH+IDX_WIDTH-1:OFS_WIDTH];
    // Offset and tag bits play no part in index arbitration.
    assign w_unused_addr = &{1'b0, cd_req_addr, su_req_addr};

    assign w_cd_own    = (r_cd_state == ST_OWN);
    assign w_su_own    = (r_su_state == ST_OWN);
    assign w_cd_starve = (r_starve_cnt == STARVE_MAX);

    // Blocking uses the registered owner state, so a done pulse frees the index
    // only from the following cycle on.
    assign w_cd_blk  = w_su_own & (w_cd_idx == r_su_own_idx);
    assign w_su_blk  = w_cd_own & (w_su_idx == r_cd_own_idx);
    assign w_tie     = cd_req_vld & su_req_vld & ~w_cd_own & ~w_su_own
                       & (w_cd_idx == w_su_idx) & ~w_cd_blk & ~w_su_blk;
    assign w_cd_lose = w_tie & ~w_cd_starve;
    assign w_su_lose = w_tie & w_cd_starve;

    assign w_cd_acc  = cd_req_vld & ~w_cd_own & ~w_cd_blk & ~w_cd_lose;
    assign w_su_acc  = su_req_vld & ~w_su_own & ~w_su_blk & ~w_su_lose;

    assign cd_req_rdy = w_cd_acc;
    assign su_req_rdy = w_su_acc;
    assign cd_own     = w_cd_own;
    assign su_own     = w_su_own;
    assign cd_own_idx = r_cd_own_idx;
    assign su_own_idx = r_su_own_idx;
    assign cd_starve  = w_cd_starve;
    assign proto_err  = r_proto_err;

    // Next-state logic for both channel FSMs and the starvation counter.
    always_comb begin
        w_cd_state_nxt   = r_cd_state;
        w_su_state_nxt   = r_su_state;
        w_starve_cnt_nxt = r_starve_cnt;

        case (r_cd_state)
            ST_FREE: begin
                if (w_cd_acc) w_cd_state_nxt = ST_OWN;
                else          w_cd_state_nxt = ST_FREE;
            end
            ST_OWN: begin
                if (cd_done) w_cd_state_nxt = ST_FREE;
                else         w_cd_state_nxt = ST_OWN;
            end
            default: w_cd_state_nxt = ST_FREE;
        endcase

        case (r_su_state)
            ST_FREE: begin
                if (w_su_acc) w_su_state_nxt = ST_OWN;
                else          w_su_state_nxt = ST_FREE;
            end
            ST_OWN: begin
                if (su_done) w_su_state_nxt = ST_FREE;
                else         w_su_state_nxt = ST_OWN;
            end
            default: w_su_state_nxt = ST_FREE;
        endcase

        if (w_cd_acc || !cd_req_vld) begin
            w_starve_cnt_nxt = 4'd0;
        end else if (!w_cd_own && (r_starve_cnt < STARVE_MAX)) begin
            w_starve_cnt_nxt = r_starve_cnt + 4'd1;
        end else begin
            w_starve_cnt_nxt = r_starve_cnt;
        end
    end

    // State, owned-index, starvation and sticky error registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cd_state   <= ST_FREE;
            r_su_state   <= ST_FREE;
            r_cd_own_idx <= '0;
            r_su_own_idx <= '0;
            r_starve_cnt <= 4'd0;
            r_proto_err  <= 1'b0;
        end else begin
            r_cd_state   <= w_cd_state_nxt;
            r_su_state   <= w_su_state_nxt;
            r_starve_cnt <= w_starve_cnt_nxt;
            if (w_cd_acc) r_cd_own_idx <= w_cd_idx;
            else          r_cd_own_idx <= r_cd_own_idx;
            if (w_su_acc) r_su_own_idx <= w_su_idx;
            else          r_su_own_idx <= r_su_own_idx;
            r_proto_err  <= r_proto_err | (cd_done & ~w_cd_own) | (su_done & ~w_su_own);
        end
    end

endmodule

// File: tb/tb_cac_port_arbiter.sv
// Bench for cac_port_arbiter: directed vector table, async-reset sequence and
// randomized traffic checked against a rule-level reference model.
module tb_cac_port_arbiter;

    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cd_req_vld = 1'b0;
    logic [31:0] cd_req_addr = 32'h0;
    logic        cd_req_rdy;
    logic        cd_done = 1'b0;
    logic        su_req_vld = 1'b0;
    logic [31:0] su_req_addr = 32'h0;
    logic        su_req_rdy;
    logic        su_done = 1'b0;
    logic        cd_own;
    logic [7:0]  cd_own_idx;
    logic        su_own;
    logic [7:0]  su_own_idx;
    logic        cd_starve;
    logic        proto_err;

    int n_cmp = 0;
    int n_err = 0;

    cac_port_arbiter #(
        .SADDR_WIDTH (32),
        .OFS_WIDTH   (6),
        .IDX_WIDTH   (8),
        .STARVE_LIMIT(LIMIT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cd_req_vld (cd_req_vld),
        .cd_req_addr(cd_req_addr),
        .cd_req_rdy (cd_req_rdy),
        .cd_done    (cd_done),
        .su_req_vld (su_req_vld),
        .su_req_addr(su_req_addr),
        .su_req_rdy (su_req_rdy),
        .su_done    (su_done),
        .cd_own     (cd_own),
        .cd_own_idx (cd_own_idx),
        .su_own     (su_own),
        .su_own_idx (su_own_idx),
        .cd_starve  (cd_starve),
        .proto_err  (proto_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        cv;
        logic [31:0] ca;
        logic        cdn;
        logic        sv;
        logic [31:0] sa;
        logic        sdn;
        logic        e_crdy;
        logic        e_srdy;
        logic        e_cown;
        logic        e_sown;
        logic [7:0]  e_cidx;
        logic [7:0]  e_sidx;
        logic        e_starve;
        logic        e_perr;
    } vec_t;

    vec_t tbl[27];

    function automatic vec_t mk(logic cv, logic [31:0] ca, logic cdn,
                                logic sv, logic [31:0] sa, logic sdn,
                                logic e_crdy, logic e_srdy, logic e_cown, logic e_sown,
                                logic [7:0] e_cidx, logic [7:0] e_sidx,
                                logic e_starve, logic e_perr);
        vec_t v;
        v.cv = cv; v.ca = ca; v.cdn = cdn; v.sv = sv; v.sa = sa; v.sdn = sdn;
        v.e_crdy = e_crdy; v.e_srdy = e_srdy; v.e_cown = e_cown; v.e_sown = e_sown;
        v.e_cidx = e_cidx; v.e_sidx = e_sidx; v.e_starve = e_starve; v.e_perr = e_perr;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model state: who owns what, blocked-cycle count, sticky error.
    bit m_cd_busy, m_su_busy, m_perr;
    int m_cd_idx, m_su_idx, m_cnt;

    function automatic int idx_of(logic [31:0] a);
        return int'((a >> 6) & 32'hFF);
    endfunction

    task automatic drive(input logic cv, input logic [31:0] ca, input logic cdn,
                         input logic sv, input logic [31:0] sa, input logic sdn);
        cd_req_vld = cv; cd_req_addr = ca; cd_done = cdn;
        su_req_vld = sv; su_req_addr = sa; su_done = sdn;
    endtask

    initial begin
        bit e_crdy, e_srdy, tie, cd_wait, su_wait;
        int ci, si;
        logic [31:0] ca, sa;
        logic cv, sv, cdn, sdn;

        //            cv  ca        cdn  sv  sa        sdn  crdy srdy cown sown cidx   sidx   stv  perr
        tbl[0]  = mk(0, 32'h0,  0, 0, 32'h0,  0, 0, 0, 0, 0, 8'd0, 8'd0, 0, 0);
        tbl[1]  = mk(1, 32'h40, 0, 0, 32'h0,  0, 1, 0, 0, 0, 8'd0, 8'd0, 0, 0);
        tbl[2]  = mk(0, 32'h0,  0, 0, 32'h0,  0, 0, 0, 1, 0, 8'd1, 8'd0, 0, 0);
        tbl[3]  = mk(0, 32'h0,  1, 0, 32'h0,  0, 0, 0, 1, 0, 8'd1, 8'd0, 0, 0);
        tbl[4]  = mk(0, 32'h0,  0, 0, 32'h0,  0, 0, 0, 0, 0, 8'd0, 8'd0, 0, 0);
        tbl[5]  = mk(1, 32'h40, 0, 1, 32'h80, 0, 1, 1, 0, 0, 8'd0, 8'd0, 0, 0);
        tbl[6]  = mk(0, 32'h0,  0, 0, 32'h0,  0, 0, 0, 1, 1, 8'd1, 8'd2, 0, 0);
        tbl[7]  = mk(0, 32'h0,  1, 0, 32'h0,  1, 0, 0, 1, 1, 8'd1, 8'd2, 0, 0);
        tbl[8]  = mk(0, 32'h0,  0, 0, 32'h0,  0, 0, 0, 0, 0, 8'd0, 8'd0, 0, 0);
        tbl[9]  = mk(0, 32'h0,  0, 1, 32'h40, 0, 0, 1, 0, 0, 8'd0, 8'd0, 0, 0);
        tbl[10] = mk(1, 32'h40, 0, 0, 32'h0,  0, 0, 0, 0, 1, 8'd0, 8'd1, 0, 0);
        tbl[11] = mk(1, 32'h40, 0, 0, 32'h0,  1, 0, 0, 0, 1, 8'd0, 8'd1, 0, 0);
        tbl[12] = mk(1, 32'h40, 0, 0, 32'h0,  0, 1, 0, 0, 0, 8'd0, 8'd0, 0, 0);
        tbl[13] = mk(0, 32'h0,  1, 0, 32'h0,  0, 0, 0, 1, 0, 8'd1, 8'd0, 0, 0);
        tbl[14] = mk(0, 32'h0,  0, 0, 32'h0,  0, 0, 0, 0, 0, 8'd0, 8'd0, 0, 0);
        tbl[15] = mk(1, 32'h40, 0, 1, 32'h40, 0, 0, 1, 0, 0, 8'd0, 8'd0, 0, 0);
        tbl[16] = mk(1, 32'h40, 0, 0, 32'h0,  0, 0, 0, 0, 1, 8'd0, 8'd1, 0, 0);
        tbl[17] = mk(1, 32'h40, 0, 0, 32'h0,  0, 0, 0, 0, 1, 8'd0, 8'd1, 0, 0);
        tbl[18] = mk(1, 32'h40, 0, 0, 32'h0,  0, 0, 0, 0, 1, 8'd0, 8'd1, 0, 0);
        tbl[19] = mk(1, 32'h40, 0, 0, 32'h0,  1, 0, 0, 0, 1, 8'd0, 8'd1, 1, 0);
        tbl[20] = mk(1, 32'h40, 0, 1, 32'h40, 0, 1, 0, 0, 0, 8'd0, 8'd0, 1, 0);
        tbl[21] = mk(0, 32'h0,  1, 1, 32'h40, 0, 0, 0, 1, 0, 8'd1, 8'd0, 0, 0);
        tbl[22] = mk(0, 32'h0,  0, 0, 32'h0,  0, 0, 0, 0, 0, 8'd0, 8'd0, 0, 0);
        tbl[23] = mk(0, 32'h0,  1, 0, 32'h0,  0, 0, 0, 0, 0, 8'd0, 8'd0, 0, 0);
        tbl[24] = mk(0, 32'h0,  0, 0, 32'h0,  0, 0, 0, 0, 0, 8'd0, 8'd0, 0, 1);
        tbl[25] = mk(0, 32'h0,  0, 0, 32'h0,  1, 0, 0, 0, 0, 8'd0, 8'd0, 0, 1);
        tbl[26] = mk(0, 32'h0,  0, 0, 32'h0,  0, 0, 0, 0, 0, 8'd0, 8'd0, 0, 1);

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 27; i++) begin
            @(negedge clk);
            drive(tbl[i].cv, tbl[i].ca, tbl[i].cdn, tbl[i].sv, tbl[i].sa, tbl[i].sdn);
            #1;
            chk($sformatf("vec%0d cd_req_rdy", i), 32'(cd_req_rdy), 32'(tbl[i].e_crdy));
            chk($sformatf("vec%0d su_req_rdy", i), 32'(su_req_rdy), 32'(tbl[i].e_srdy));
            chk($sformatf("vec%0d cd_own", i),     32'(cd_own),     32'(tbl[i].e_cown));
            chk($sformatf("vec%0d su_own", i),     32'(su_own),     32'(tbl[i].e_sown));
            chk($sformatf("vec%0d cd_starve", i),  32'(cd_starve),  32'(tbl[i].e_starve));
            chk($sformatf("vec%0d proto_err", i),  32'(proto_err),  32'(tbl[i].e_perr));
            if (tbl[i].e_cown) chk($sformatf("vec%0d cd_own_idx", i), 32'(cd_own_idx), 32'(tbl[i].e_cidx));
            if (tbl[i].e_sown) chk($sformatf("vec%0d su_own_idx", i), 32'(su_own_idx), 32'(tbl[i].e_sidx));
        end

        // Both channels owning, then reset asserted between clock edges.
        @(negedge clk);
        drive(1'b1, 32'h0000_0040, 1'b0, 1'b1, 32'h0000_0080, 1'b0);
        @(negedge clk);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        #1;
        chk("pre_rst cd_own", 32'(cd_own), 32'd1);
        chk("pre_rst su_own", 32'(su_own), 32'd1);
        chk("pre_rst su_own_idx", 32'(su_own_idx), 32'd2);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst cd_own", 32'(cd_own), 32'd0);
        chk("async_rst su_own", 32'(su_own), 32'd0);
        chk("async_rst cd_own_idx", 32'(cd_own_idx), 32'd0);
        chk("async_rst su_own_idx", 32'(su_own_idx), 32'd0);
        chk("async_rst proto_err", 32'(proto_err), 32'd0);
        chk("async_rst cd_starve", 32'(cd_starve), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        m_cd_busy = 0; m_su_busy = 0; m_perr = 0;
        m_cd_idx = 0; m_su_idx = 0; m_cnt = 0;

        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            cv  = ($urandom_range(0, 99) < 65);
            sv  = ($urandom_range(0, 99) < 50);
            ca  = ($urandom & 32'hFFFF_C03F) | (32'($urandom_range(0, 3)) << 6);
            sa  = ($urandom & 32'hFFFF_C03F) | (32'($urandom_range(0, 3)) << 6);
            cdn = m_cd_busy ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 299) == 0);
            sdn = m_su_busy ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 299) == 0);
            drive(cv, ca, cdn, sv, sa, sdn);

            ci = idx_of(ca);
            si = idx_of(sa);
            cd_wait = m_su_busy && (ci == m_su_idx);
            su_wait = m_cd_busy && (si == m_cd_idx);
            tie     = cv && sv && !m_cd_busy && !m_su_busy && (ci == si);
            e_crdy  = cv && !m_cd_busy && !cd_wait && !(tie && (m_cnt != LIMIT));
            e_srdy  = sv && !m_su_busy && !su_wait && !(tie && (m_cnt == LIMIT));

            #1;
            chk($sformatf("rnd%0d cd_req_rdy", c), 32'(cd_req_rdy), 32'(e_crdy));
            chk($sformatf("rnd%0d su_req_rdy", c), 32'(su_req_rdy), 32'(e_srdy));
            chk($sformatf("rnd%0d cd_own", c),     32'(cd_own),     32'(m_cd_busy));
            chk($sformatf("rnd%0d su_own", c),     32'(su_own),     32'(m_su_busy));
            chk($sformatf("rnd%0d cd_starve", c),  32'(cd_starve),  32'(m_cnt == LIMIT));
            chk($sformatf("rnd%0d proto_err", c),  32'(proto_err),  32'(m_perr));
            if (m_cd_busy) chk($sformatf("rnd%0d cd_own_idx", c), 32'(cd_own_idx), 32'(m_cd_idx));
            if (m_su_busy) chk($sformatf("rnd%0d su_own_idx", c), 32'(su_own_idx), 32'(m_su_idx));

            @(posedge clk);
            if (cdn && !m_cd_busy) m_perr = 1;
            if (sdn && !m_su_busy) m_perr = 1;
            if (!cv || e_crdy)              m_cnt = 0;
            else if (!m_cd_busy && m_cnt < LIMIT) m_cnt = m_cnt + 1;
            if (m_cd_busy && cdn) m_cd_busy = 0;
            if (m_su_busy && sdn) m_su_busy = 0;
            if (e_crdy) begin m_cd_busy = 1; m_cd_idx = ci; end
            if (e_srdy) begin m_su_busy = 1; m_su_idx = si; end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
